// File: rtl/dma_burst_scheduler.sv
// Job-level burst sequencer for the Dma read/write channel pair.
// Define DMA_SCHED_4K_SPLIT_EN to keep every burst inside a 4 KB page.
module dma_burst_scheduler #(
  parameter int DMA_AXI_ADDR_WIDTH = 32,
  parameter int MAX_BURST_BEATS    = 16,
  parameter int JOB_BEATS_WIDTH    = 16
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,
  input  logic                          job_valid_i,
  output logic                          job_ready_o,
  input  logic [DMA_AXI_ADDR_WIDTH-1:0] job_src_addr_i,
  input  logic [DMA_AXI_ADDR_WIDTH-1:0] job_dst_addr_i,
  input  logic [JOB_BEATS_WIDTH-1:0]    job_beats_i,
  input  logic [2:0]                    job_size_i,
  output logic                          job_done_o,
  output logic                          read_start_o,
  output logic [DMA_AXI_ADDR_WIDTH-1:0] read_addr_o,
  output logic [7:0]                    read_len_o,
  output logic [2:0]                    read_size_o,
  input  logic                          read_busy_i,
  output logic                          write_start_o,
  output logic [DMA_AXI_ADDR_WIDTH-1:0] write_addr_o,
  output logic [7:0]                    write_len_o,
  output logic [2:0]                    write_size_o,
  input  logic                          write_busy_i
);

  localparam int AW  = DMA_AXI_ADDR_WIDTH;
  localparam int JBW = JOB_BEATS_WIDTH;
  localparam int CW  = ((JBW > 13) ? JBW : 13) + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CALC  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] ACK   = 3'd3;
  localparam logic [2:0] RUN   = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;

  // Index 0 is the read side, index 1 the write side.
  logic [2:0]     state_q   [2];
  logic [2:0]     state_d   [2];
  logic [AW-1:0]  addr_q    [2];
  logic [AW-1:0]  addr_d    [2];
  logic [AW-1:0]  outAddr_q [2];
  logic [AW-1:0]  outAddr_d [2];
  logic [JBW-1:0] rem_q     [2];
  logic [JBW-1:0] rem_d     [2];
  logic [8:0]     len_q     [2];
  logic [8:0]     len_d     [2];
  logic [7:0]     outLen_q  [2];
  logic [7:0]     outLen_d  [2];
  logic [8:0]     burstLen  [2];
  logic [CW-1:0]  lim       [2];
`ifdef DMA_SCHED_4K_SPLIT_EN
  logic [12:0]    toBoundary[2];
`endif
  logic [2:0]     size_q, size_d;
  logic [1:0]     busy;
  logic           bothIdle, bothFin, accept;

  assign busy = {write_busy_i, read_busy_i};

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      lim[s] = CW'(MAX_BURST_BEATS);
      if (CW'(rem_q[s]) < lim[s]) lim[s] = CW'(rem_q[s]);
`ifdef DMA_SCHED_4K_SPLIT_EN
      toBoundary[s] = (13'd4096 - {1'b0, addr_q[s][11:0]}) >> size_q;
      if (CW'(toBoundary[s]) < lim[s]) lim[s] = CW'(toBoundary[s]);
`endif
      burstLen[s] = lim[s][8:0];
    end
  end

  // Completion is decoded from both sides parking in FIN; a job offered in
  // that same cycle is loaded directly instead of passing through IDLE.
  always_comb begin
    bothIdle    = (state_q[0] == IDLE) && (state_q[1] == IDLE);
    bothFin     = (state_q[0] == FIN) && (state_q[1] == FIN);
    job_ready_o = bothIdle || bothFin;
    job_done_o  = bothFin;
    accept      = job_valid_i && job_ready_o;
    size_d      = accept ? job_size_i : size_q;
    for (int s = 0; s < 2; s++) begin
      state_d[s]   = state_q[s];
      addr_d[s]    = addr_q[s];
      rem_d[s]     = rem_q[s];
      len_d[s]     = len_q[s];
      outAddr_d[s] = outAddr_q[s];
      outLen_d[s]  = outLen_q[s];
      case (state_q[s])
        IDLE, FIN: begin
          if (state_q[s] == FIN && bothFin) state_d[s] = IDLE;
          if (accept) begin
            addr_d[s]  = (s == 0) ? job_src_addr_i : job_dst_addr_i;
            rem_d[s]   = job_beats_i;
            state_d[s] = (job_beats_i != '0) ? CALC : FIN;
          end
        end
        CALC: begin
          outAddr_d[s] = addr_q[s];
          outLen_d[s]  = 8'(burstLen[s] - 9'd1);
          len_d[s]     = burstLen[s];
          state_d[s]   = ISSUE;
        end
        ISSUE: state_d[s] = ACK;
        ACK: if (busy[s]) state_d[s] = RUN;
        RUN: begin
          if (!busy[s]) begin
            addr_d[s]  = addr_q[s] + (AW'(len_q[s]) << size_q);
            rem_d[s]   = rem_q[s] - JBW'(len_q[s]);
            state_d[s] = (rem_q[s] == JBW'(len_q[s])) ? FIN : CALC;
          end
        end
        default: state_d[s] = IDLE;
      endcase
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      size_q <= '0;
      for (int s = 0; s < 2; s++) begin
        state_q[s]   <= IDLE;
        addr_q[s]    <= '0;
        rem_q[s]     <= '0;
        len_q[s]     <= '0;
        outAddr_q[s] <= '0;
        outLen_q[s]  <= '0;
      end
    end else begin
      size_q <= size_d;
      for (int s = 0; s < 2; s++) begin
        state_q[s]   <= state_d[s];
        addr_q[s]    <= addr_d[s];
        rem_q[s]     <= rem_d[s];
        len_q[s]     <= len_d[s];
        outAddr_q[s] <= outAddr_d[s];
        outLen_q[s]  <= outLen_d[s];
      end
    end
  end

  assign read_start_o  = (state_q[0] == ISSUE);
  assign write_start_o = (state_q[1] == ISSUE);
  assign read_addr_o   = outAddr_q[0];
  assign write_addr_o  = outAddr_q[1];
  assign read_len_o    = outLen_q[0];
  assign write_len_o   = outLen_q[1];
  assign read_size_o   = size_q;
  assign write_size_o  = size_q;

endmodule
